// File: rtl/dram_arb_pkg.sv
// Shared types and sizes for the data-RAM port arbiter.
package dram_arb_pkg;

   localparam int unsigned NCORES    = 4;
   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned CORE_ID_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [NCORES-1:0] core_onehot(input logic [CORE_ID_W-1:0] id);
      return NCORES'(1) << id;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: first requester at or after ptr, modulo 4.
module rr_pick4
   import dram_arb_pkg::*;
(
   input  logic [3:0]           req,
   input  logic [CORE_ID_W-1:0] ptr,
   output logic                 any,
   output logic [CORE_ID_W-1:0] winner
);

   logic                 found;
   logic [CORE_ID_W-1:0] idx;

   always_comb begin
      any    = |req;
      winner = ptr;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr + CORE_ID_W'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among four cores;
// one fixed-latency, non-pipelined transaction at a time.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned NCORES = dram_arb_pkg::NCORES,
   parameter int unsigned ADDR_W = dram_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W = dram_arb_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     controlRST,
   input  logic [NCORES-1:0]        req,
   input  logic [NCORES-1:0]        we,
   input  logic [NCORES*ADDR_W-1:0] addr,
   input  logic [NCORES*DATA_W-1:0] wdata,
   output logic [NCORES-1:0]        ack,
   output logic [DATA_W-1:0]        rdata,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_wren,
   input  logic [DATA_W-1:0]        mem_q,
   output logic [CORE_ID_W-1:0]     grant_id,
   output logic                     busy
);

   state_t               state_q, state_d;
   logic [CORE_ID_W-1:0] ptr_q, ptr_d;
   logic                 any;
   logic [CORE_ID_W-1:0] winner;

   logic [NCORES-1:0]    ack_d;
   logic [DATA_W-1:0]    rdata_d;
   logic [ADDR_W-1:0]    mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_d;
   logic                 mem_wren_d;
   logic [CORE_ID_W-1:0] grant_d;
   logic                 busy_d;

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .any    (any),
      .winner (winner)
   );

   // State register
   always_ff @(posedge clk or negedge controlRST) begin
      if (!controlRST) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next state; mem_wren still holds the granted write flag during ISSUE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any) state_d = ISSUE;
         ISSUE:   state_d = mem_wren ? DONE : WAIT;
         WAIT:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; ack is set on entry to DONE
   always_comb begin
      ack_d       = '0;
      rdata_d     = rdata;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_wren_d  = 1'b0;
      grant_d     = grant_id;
      ptr_d       = ptr_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               grant_d     = winner;
               mem_addr_d  = addr[winner*ADDR_W +: ADDR_W];
               mem_wdata_d = wdata[winner*DATA_W +: DATA_W];
               mem_wren_d  = we[winner];
               ptr_d       = CORE_ID_W'(winner + 1'b1);
            end
         end
         ISSUE: begin
            if (mem_wren) ack_d = core_onehot(grant_id);
         end
         WAIT: begin
            rdata_d = mem_q;
            ack_d   = core_onehot(grant_id);
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Output and pointer registers
   always_ff @(posedge clk or negedge controlRST) begin
      if (!controlRST) begin
         ack       <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wren  <= 1'b0;
         grant_id  <= '0;
         busy      <= 1'b0;
         ptr_q     <= '0;
      end else begin
         ack       <= ack_d;
         rdata     <= rdata_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         mem_wren  <= mem_wren_d;
         grant_id  <= grant_d;
         busy      <= busy_d;
         ptr_q     <= ptr_d;
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_dram_port_arbiter;

   logic        clk;
   logic        controlRST;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [3:0]  ack;
   logic [15:0] rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_wren;
   logic [15:0] mem_q;
   logic [1:0]  grant_id;
   logic        busy;

   typedef struct {
      int          core;
      bit          w;
      logic [15:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] ram [0:65535];
   logic [3:0]  keep;
   int          n_cmp;
   int          n_bad;

   dram_port_arbiter dut (
      .clk        (clk),
      .controlRST (controlRST),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .ack        (ack),
      .rdata      (rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wren   (mem_wren),
      .mem_q      (mem_q),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM, one-cycle read latency
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input bit w, input logic [15:0] rd);
      exp_t e;
      e.core = k;
      e.w    = w;
      e.rd   = rd;
      sb.push_back(e);
   endtask

   task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [15:0] d);
      we[k]             = w;
      addr[k*16 +: 16]  = a;
      wdata[k*16 +: 16] = d;
      req[k]            = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(busy == 1'b0 && req == 4'b0) && c < budget);
      if (!(busy == 1'b0 && req == 4'b0)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: busy=%0b req=%b after %0d cycles", busy, req, c);
      end
   endtask

   // One transaction with latency, grant and write-enable pulse checks
   task automatic run_one(input int k, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] rd, input int lat);
      int got_lat;
      int wren_cnt;
      logic [15:0] wren_addr;
      got_lat   = 0;
      wren_cnt  = 0;
      wren_addr = '0;
      push(k, w, rd);
      issue(k, w, a, d);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) chk("grant_id", 32'(grant_id), 32'(k));
         if (mem_wren) begin
            wren_cnt++;
            wren_addr = mem_addr;
         end
         if (ack != 4'b0) begin
            got_lat = c;
            break;
         end
      end
      chk("latency", got_lat, lat);
      chk("wren_cycles", wren_cnt, w ? 1 : 0);
      if (w) chk("wren_addr", 32'(wren_addr), 32'(a));
      wait_quiet(20);
   endtask

   // Core model: drop req on seeing ack unless the core is pinned high
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++)
            if (ack[k] && !keep[k]) req[k] = 1'b0;
      end
   end

   // Monitor: every ack pops the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack != 4'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'h0);
            end else begin
               e = sb.pop_front();
               chk("ack_core", 32'(ack), 32'(1) << e.core);
               if (!e.w) chk("rdata", 32'(rdata), 32'(e.rd));
            end
         end
      end
   end

   task automatic do_reset();
      controlRST = 1'b0;
      repeat (2) @(negedge clk);
      controlRST = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n0;
      int busy_cnt;
      n_cmp = 0;
      n_bad = 0;
      keep  = '0;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      controlRST = 1'b0;
      ram[16'h0010] = 16'hBEEF;
      ram[16'h0020] = 16'hC000;
      ram[16'h0021] = 16'hC111;
      ram[16'h0022] = 16'hC222;
      ram[16'h0023] = 16'hC333;

      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      chk("rst_mem_wren", 32'(mem_wren), 32'h0);
      chk("rst_grant_id", 32'(grant_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      controlRST = 1'b1;
      @(negedge clk);

      // Single read, then write followed by read-back from another core
      run_one(2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3);
      run_one(0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 2);
      chk("rdata_hold_on_write", 32'(rdata), 32'hBEEF);
      run_one(3, 1'b0, 16'h0005, 16'h0000, 16'h1234, 3);

      // All four from reset: order 0,1,2,3
      do_reset();
      for (int k = 0; k < 4; k++) push(k, 1'b0, 16'hC000 + 16'(k) * 16'h0111);
      for (int k = 0; k < 4; k++) issue(k, 1'b0, 16'h0020 + 16'(k), 16'h0000);
      wait_quiet(80);

      // Second burst with ptr back at 0, as writes
      for (int k = 0; k < 4; k++) push(k, 1'b1, 16'h0000);
      for (int k = 0; k < 4; k++) issue(k, 1'b1, 16'h0030 + 16'(k), 16'h5000 + 16'(k));
      wait_quiet(80);
      for (int k = 0; k < 4; k++) chk("burst_write", 32'(ram[16'h0030 + 16'(k)]), 32'h5000 + k);

      // ptr to 2, then cores 3 and 1 together: 3 wins, then 1
      run_one(1, 1'b0, 16'h0021, 16'h0000, 16'hC111, 3);
      push(3, 1'b0, 16'hC333);
      push(1, 1'b0, 16'hC222);
      issue(3, 1'b0, 16'h0023, 16'h0000);
      issue(1, 1'b0, 16'h0022, 16'h0000);
      wait_quiet(40);

      // Fairness: core 0 pinned high, core 1 asks once
      keep[0] = 1'b1;
      push(0, 1'b0, 16'hC000);
      issue(0, 1'b0, 16'h0020, 16'h0000);
      @(negedge clk);
      push(1, 1'b0, 16'hC111);
      push(0, 1'b0, 16'hC000);
      issue(1, 1'b0, 16'h0021, 16'h0000);
      n0 = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ack[0]) n0++;
         if (ack[1]) break;
      end
      keep[0] = 1'b0;
      chk("fair_core0_before_core1", n0, 1);
      wait_quiet(30);

      // Reset during WAIT of a read: no ack, outputs cleared, re-issue completes
      issue(2, 1'b0, 16'h0010, 16'h0000);
      repeat (2) @(negedge clk);
      controlRST = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack), 32'h0);
      chk("midrst_rdata", 32'(rdata), 32'h0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
      chk("midrst_mem_wren", 32'(mem_wren), 32'h0);
      chk("midrst_grant_id", 32'(grant_id), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      chk("midrst_busy_held", 32'(busy), 32'h0);
      push(2, 1'b0, 16'hBEEF);
      controlRST = 1'b1;
      wait_quiet(20);
      chk("midrst_reissue_rdata", 32'(rdata), 32'hBEEF);

      // Core 1 drops req during ISSUE of a write
      push(1, 1'b1, 16'h0000);
      issue(1, 1'b1, 16'h0040, 16'h0BAD);
      @(negedge clk);
      req[1] = 1'b0;
      wait_quiet(20);
      busy_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("drop_no_regrant", busy_cnt, 0);
      chk("drop_write_landed", 32'(ram[16'h0040]), 32'h0BAD);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Shares one single-port synchronous data RAM among the four `phase_6` cores of the multicore build. It sits between each core's address/data registers (AR/DR path) and the data RAM port. It grants one core at a time in round-robin order, drives the RAM address, write-data and write-enable, and returns read data with a per-core acknowledge. Each access is a fixed-latency, non-pipelined transaction, which keeps core stall behaviour deterministic.

## Interface
Parameters:
- `NCORES`, 4 — number of requesting cores; fixed at 4 in this release.
- `ADDR_W`, 16 — data-RAM address width, same as core AR width.
- `DATA_W`, 16 — data-RAM word width, same as core DR width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — system clock (the scaled core clock).
- `controlRST`  in  1  — asynchronous, active-low reset.
- `req`  in  NCORES  — per-core access request; the core holds it high until it sees its `ack` bit.
- `we`  in  NCORES  — per-core write flag (1 = write, 0 = read); held stable with `req`.
- `addr`  in  NCORES*ADDR_W  — per-core address; core k uses bits [k*ADDR_W +: ADDR_W].
- `wdata`  in  NCORES*DATA_W  — per-core write data; same packing as `addr`.
- `ack`  out  NCORES  — one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  — read data, valid only while the matching `ack` bit is high.
- `mem_addr`  out  ADDR_W  — RAM address, registered.
- `mem_wdata`  out  DATA_W  — RAM write data, registered.
- `mem_wren`  out  1  — RAM write enable, registered.
- `mem_q`  in  DATA_W  — RAM read data; 1-cycle latency after the address is sampled.
- `grant_id`  out  2  — index of the core currently granted; for debug and the output mux.
- `busy`  out  1  — high in every state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req` bit is high, pick a winner g by round-robin.
  - Register `grant_id`←g.
  - Register `mem_addr`←addr[g], `mem_wdata`←wdata[g], `mem_wren`←we[g].
  - Go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE: the RAM samples `mem_addr`, and `mem_wdata` when `mem_wren` is high.
  - Clear `mem_wren` at the end of the cycle.
  - Write: go to DONE. Read: go to WAIT.
- WAIT: `mem_q` is valid; capture it into `rdata` at the end of the cycle, then go to DONE.
- DONE: `ack[grant_id]`=1 for this single cycle, then go to IDLE.
  - The core drops `req` on the edge that ends DONE, so the same request is never granted twice.
- Round-robin rule:
  - The priority pointer `ptr` resets to 0.
  - The search runs ptr, ptr+1, … modulo 4.
  - On every grant, `ptr`←(g+1) mod 4, wrapping from 3 to 0.
- Requests that arrive or change outside IDLE are ignored until the next IDLE.
- Simultaneous requests: exactly one is granted; the others wait, with latency bounded by 3 transactions.
- If a core drops `req` mid-transaction, the transaction still completes (the write is performed) and `ack` still pulses; the core ignores it.
- `rdata` holds its last value between reads. On writes `rdata` is not updated.
- Reset (asserted at any time, including mid-transaction):
  - State→IDLE, `ptr`=0.
  - `ack`=0, `rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wren`=0, `grant_id`=0, `busy`=0.
  - An in-flight transaction is abandoned without `ack`; the core re-issues it after reset.

## Timing
- `req` sampled in IDLE at cycle N.
- Write: `mem_wren`=1 during N+1; `ack` during N+2. That is 3 cycles per write.
- Read: `mem_addr` valid during N+1; `mem_q` valid N+2; `ack` and `rdata` during N+3. That is 4 cycles per read.
- Back-to-back transactions: the next IDLE is the cycle after DONE. Minimum spacing between grants is 3 cycles (write) or 4 cycles (read).
- All outputs are registered; there is no combinational path from `req`/`addr` to any output.

## Structure
- A shared package `dram_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - `NCORES`, `ADDR_W`, `DATA_W`;
  - `CORE_ID_W`=2.
- One sub-module, `rr_pick4`: a combinational round-robin selector.
  - Inputs: `req`[3:0], `ptr`[1:0].
  - Outputs: `any`, `winner`[1:0].
  - The pointer register lives in the parent.

## Test plan
- Single read: core 2 reads address 0x0010, RAM preloaded with 0xBEEF → `ack`=4'b0100 exactly 3 cycles after grant; `rdata`=0xBEEF.
- Single write then read: core 0 writes 0x1234 to 0x0005 → `mem_wren` is high for exactly one cycle with `mem_addr`=0x0005. A following read by core 3 returns 0x1234.
- All four cores request together from reset → grants in order 0,1,2,3. A second burst with `ptr`=0 repeats 0,1,2,3. With only cores 3 and 1 requesting and `ptr`=2 → order 3 then 1 (wrap).
- Fairness: core 0 keeps `req` permanently high while core 1 requests once → core 1 is granted no later than the second transaction after its request.
- Reset mid-read: assert `controlRST` low during WAIT → no `ack`; all outputs 0 while reset is low; after release the re-issued read completes normally.
- Dropped request: core 1 drops `req` during ISSUE of a write → the write still lands and `ack[1]` still pulses once. The FSM returns to IDLE and no regrant to core 1 occurs.
